// File: rtl/conf_mul_pkg.sv
// Shared constants and precision helpers for the configurable-precision multiplier.
// The mask helpers are sized by MAX_W_DEF, so instantiations keep MAX_W equal to it.
package conf_mul_pkg;

  localparam int unsigned MAX_W_DEF  = 24;
  localparam int unsigned PREC_W_DEF = 5;

  // Number of operand LSBs dropped for a requested precision; prec==0 keeps one bit.
  function automatic int unsigned clamp_prec(input int unsigned prec);
    int unsigned p_eff;
    if (prec == 0) begin
      p_eff = 1;
    end else if (prec > MAX_W_DEF) begin
      p_eff = MAX_W_DEF;
    end else begin
      p_eff = prec;
    end
    return MAX_W_DEF - p_eff;
  endfunction

  // Ones in the low t bits; t >= MAX_W_DEF yields all ones.
  function automatic logic [MAX_W_DEF-1:0] low_mask(input int unsigned t);
    return ~({MAX_W_DEF{1'b1}} << t);
  endfunction

endpackage

// File: rtl/conf_int_mul__apx_mask.sv
// Operand masking: derives the truncation amount from acc_sel/prec and clears
// the dropped operand LSBs before they reach the multiplier.
module conf_int_mul__apx_mask
  import conf_mul_pkg::*;
#(
  parameter int MAX_W  = MAX_W_DEF,
  parameter int PREC_W = PREC_W_DEF
) (
  input  logic [MAX_W-1:0]  a_i,
  input  logic [MAX_W-1:0]  b_i,
  input  logic              acc_sel_i,
  input  logic [PREC_W-1:0] prec_i,
  output logic [MAX_W-1:0]  a_m_o,
  output logic [MAX_W-1:0]  b_m_o,
  output logic [PREC_W-1:0] t_o,
  output logic              apx_o
);

  int unsigned      t_int;
  logic [MAX_W-1:0] keep;

  always_comb begin
    if (acc_sel_i) begin
      t_int = 0;
    end else begin
      t_int = clamp_prec(32'(prec_i));
    end
    keep = ~low_mask(t_int);
  end

  assign a_m_o = a_i & keep;
  assign b_m_o = b_i & keep;
  assign t_o   = PREC_W'(t_int);
  assign apx_o = (t_int != 0);

endmodule

// File: rtl/conf_int_mul__pipe__apx_sel.sv
// Two-stage configurable-precision unsigned multiplier with valid/ready flow
// control, an approximate-result tag and a saturating approximate-op counter.
module conf_int_mul__pipe__apx_sel
  import conf_mul_pkg::*;
#(
  parameter int MAX_W  = MAX_W_DEF,
  parameter int PREC_W = PREC_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MAX_W-1:0]   a,
  input  logic [MAX_W-1:0]   b,
  input  logic               acc_sel,
  input  logic [PREC_W-1:0]  prec,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*MAX_W-1:0] d,
  output logic               d_apx,
  output logic [CNT_W-1:0]   apx_cnt,
  input  logic               cnt_clr
);

  localparam int P_W = 2 * MAX_W;

  // Handshake: a beat transfers on a rising edge where valid && ready. The whole
  // pipe advances when the output slot is empty or being drained (adv); otherwise
  // every stage holds and d/d_apx stay stable. in_ready never depends on in_valid.
  logic adv;
  logic accept;

  logic [MAX_W-1:0]  a_m;
  logic [MAX_W-1:0]  b_m;
  logic [PREC_W-1:0] t_new;
  logic              apx_new;

  logic              s1_valid_q, s1_valid_d;
  logic [MAX_W-1:0]  s1_a_q, s1_a_d;
  logic [MAX_W-1:0]  s1_b_q, s1_b_d;
  logic [PREC_W-1:0] s1_t_q, s1_t_d;
  logic              s1_apx_q, s1_apx_d;

  logic              out_valid_q, out_valid_d;
  logic [P_W-1:0]    d_q, d_d;
  logic              d_apx_q, d_apx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [P_W-1:0]    prod;
  logic [P_W-1:0]    zero_mask;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv && rst;
  assign accept   = in_valid && in_ready;

  conf_int_mul__apx_mask #(
    .MAX_W  (MAX_W),
    .PREC_W (PREC_W)
  ) u_apx_mask (
    .a_i       (a),
    .b_i       (b),
    .acc_sel_i (acc_sel),
    .prec_i    (prec),
    .a_m_o     (a_m),
    .b_m_o     (b_m),
    .t_o       (t_new),
    .apx_o     (apx_new)
  );

  assign prod = P_W'(s1_a_q) * P_W'(s1_b_q);

  // Low 2t product bits, built from two operand-width masks (upper half only when 2t > MAX_W).
  always_comb begin
    int unsigned two_t;
    int unsigned hi_t;
    two_t = 32'(s1_t_q) << 1;
    if (two_t > MAX_W) begin
      hi_t = two_t - MAX_W;
    end else begin
      hi_t = 0;
    end
    zero_mask = {low_mask(hi_t), low_mask(two_t)};
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_t_d      = s1_t_q;
    s1_apx_d    = s1_apx_q;
    out_valid_d = out_valid_q;
    d_d         = d_q;
    d_apx_d     = d_apx_q;
    if (adv) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_a_d   = a_m;
        s1_b_d   = b_m;
        s1_t_d   = t_new;
        s1_apx_d = apx_new;
      end
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        d_d     = prod & ~zero_mask;
        d_apx_d = s1_apx_q;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (accept && apx_new && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_t_q      <= '0;
      s1_apx_q    <= 1'b0;
      out_valid_q <= 1'b0;
      d_q         <= '0;
      d_apx_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_t_q      <= s1_t_d;
      s1_apx_q    <= s1_apx_d;
      out_valid_q <= out_valid_d;
      d_q         <= d_d;
      d_apx_q     <= d_apx_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign d         = d_q;
  assign d_apx     = d_apx_q;
  assign apx_cnt   = cnt_q;

endmodule
